// File: rtl/dcu_sched_pkg.sv
// Shared constants and state encoding for the DCU scheduler.
// Holds default geometry (histogram stride, training-set size, watchdog
// limit), datapath widths, the "no result yet" distance and the FSM encoding.
package dcu_sched_pkg;

    localparam int HIST_BYTES_DFLT = 1024;
    localparam int MAX_TRAIN_DFLT  = 2048;
    localparam int WAIT_LIMIT_DFLT = 4096;

    localparam int DIST_W = 18;
    localparam int IDX_W  = 11;
    localparam int OFS_W  = 21;
    localparam int NUM_W  = 12;

    localparam logic [DIST_W-1:0] DIST_MAX = 18'h3FFFF;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

endpackage

// File: rtl/dcu_argmin.sv
// Running minimum tracker for the nearest-neighbour search.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           reload best_distance=DIST_MAX, best_index=0
//   strobe          qualifies index/distance as a new candidate
//   index, distance candidate sample
//   best_index, best_distance  current minimum
// Strict less-than means the first (lowest) index wins on a tie, since
// samples are presented in ascending index order.
module dcu_argmin
    import dcu_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              strobe,
    input  logic [IDX_W-1:0]  index,
    input  logic [DIST_W-1:0] distance,
    output logic [IDX_W-1:0]  best_index,
    output logic [DIST_W-1:0] best_distance
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_distance <= DIST_MAX;
            best_index    <= '0;
        end else if (strobe && (distance < best_distance)) begin
            best_distance <= distance;
            best_index    <= index;
        end
    end

endmodule

// File: rtl/dcu_scheduler.sv
// Sequencing controller for the distance compute unit.
// Walks samples 0..num_train-1: one ISSUE cycle pulses dcu_enable with the
// sample's histogram offset, then WAIT holds until dcu_valid (or the
// watchdog expires). Returned distances feed dcu_argmin.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort, num_train  run control
//   busy, done, error        run status (error is sticky until next start)
//   dcu_enable, dcu_offset   launch interface to the DCU
//   dcu_distance, dcu_valid  result interface from the DCU
//   best_index, best_distance, best_valid  nearest-neighbour result
module dcu_scheduler
    import dcu_sched_pkg::*;
#(
    parameter int HIST_BYTES = HIST_BYTES_DFLT,
    parameter int MAX_TRAIN  = MAX_TRAIN_DFLT,
    parameter int WAIT_LIMIT = WAIT_LIMIT_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_W-1:0]  num_train,
    output logic              busy,
    output logic              dcu_enable,
    output logic [OFS_W-1:0]  dcu_offset,
    input  logic [DIST_W-1:0] dcu_distance,
    input  logic              dcu_valid,
    output logic [IDX_W-1:0]  best_index,
    output logic [DIST_W-1:0] best_distance,
    output logic              best_valid,
    output logic              done,
    output logic              error
);

    localparam int OFS_SHIFT = $clog2(HIST_BYTES);
    localparam int WD_W      = $clog2(WAIT_LIMIT);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [NUM_W-1:0]   n_train;
    logic [WD_W-1:0]    wd;
    logic [NUM_W-1:0]   n_clamped;
    logic               accept;
    logic               last;
    logic               take;

    assign n_clamped = (num_train > NUM_W'(MAX_TRAIN)) ? NUM_W'(MAX_TRAIN) : num_train;
    assign accept    = (state == ST_IDLE) && start;
    assign last      = ({1'b0, idx} == (n_train - 12'd1));
    // Abort beats a coincident result: the candidate is discarded.
    assign take      = (state == ST_WAIT) && dcu_valid && !abort;

    assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
    assign dcu_enable = (state == ST_ISSUE) && !abort;
    assign done       = ((state == ST_DONE) || (state == ST_ERR)) && !abort;
    // Power-of-two stride: offset is the index shifted into the upper bits.
    assign dcu_offset = {idx, {OFS_SHIFT{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            n_train    <= '0;
            wd         <= '0;
            best_valid <= 1'b0;
            error      <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            state      <= ST_IDLE;
            best_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        n_train    <= n_clamped;
                        best_valid <= 1'b0;
                        error      <= 1'b0;
                        state      <= (n_clamped == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dcu_valid) begin
                        if (last) begin
                            best_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end else if (wd == WD_W'(WAIT_LIMIT - 1)) begin
                        error      <= 1'b1;
                        best_valid <= 1'b0;
                        state      <= ST_ERR;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    dcu_argmin u_argmin (
        .clk           (clk),
        .rst           (rst),
        .clear         (accept && (n_clamped != '0)),
        .strobe        (take),
        .index         (idx),
        .distance      (dcu_distance),
        .best_index    (best_index),
        .best_distance (best_distance)
    );

endmodule

// File: doc/dcu_scheduler.md
# dcu_scheduler

Sequencing controller for the distance compute unit (DCU). On `start` it steps the DCU through every stored training histogram, one at a time, by issuing an enable pulse with the matching histogram base offset. It collects each returned distance and tracks the nearest neighbour (minimum distance and its index). It sits between the classifier top level and the DCU and owns the DCU's `enable` and `hist_addr_offset` inputs.

## Interface
- HIST_BYTES, 1024: bytes per training histogram; offset stride.
- MAX_TRAIN, 2048: maximum training samples; MAX_TRAIN×HIST_BYTES must equal 2^21.
- WAIT_LIMIT, 4096: maximum cycles to wait for `dcu_valid` per sample before aborting with an error.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  stops the current run; honoured in any state other than IDLE.
- num_train  in  12  number of samples to scan, 0..2048.
- busy  out  1  high from the cycle after `start` is accepted until the cycle DONE or ERR is entered.
- dcu_enable  out  1  one-cycle pulse that launches one DCU comparison.
- dcu_offset  out  21  histogram base address; held stable from the pulse until the matching `dcu_valid`.
- dcu_distance  in  18  distance returned by the DCU.
- dcu_valid  in  1  one-cycle strobe that qualifies `dcu_distance`.
- best_index  out  11  index of the nearest sample.
- best_distance  out  18  distance of the nearest sample.
- best_valid  out  1  high when `best_*` hold a result from a completed run.
- done  out  1  one-cycle pulse at the end of a run (normal completion or timeout).
- error  out  1  sticky timeout flag; cleared by the next accepted `start` or by `rst`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - `start`=1 with `num_train`>0: load idx=0, best_distance=18'h3FFFF, best_index=0; clear best_valid and error; go to ISSUE.
  - `start`=1 with `num_train`=0: go to DONE with best_valid=0.
- ISSUE:
  - Assert `dcu_enable` for exactly one cycle.
  - `dcu_offset` = idx × HIST_BYTES, which is {idx, 10'b0} at the defaults.
  - Clear the watchdog counter; go to WAIT.
- WAIT, on `dcu_valid`:
  - Compare: update the best when `dcu_distance` < best_distance, strictly less. On a tie the lower index wins.
  - If idx = num_train−1, go to DONE. Otherwise idx++ and go to ISSUE.
- WAIT, timeout: if the watchdog reaches WAIT_LIMIT−1 without `dcu_valid`, go to ERR.
- DONE: pulse `done`; set best_valid=1 if num_train>0; go to IDLE.
- ERR: pulse `done`; set `error`=1; best_valid=0; go to IDLE.
- `abort` in ISSUE, WAIT or DONE: go to IDLE on the next edge.
  - No `done`; best_valid=0.
  - `dcu_enable` is forced low in the abort cycle.
- `dcu_valid` outside WAIT is ignored; no counter or best update.
- `start` while not in IDLE is ignored.
- `num_train` > 2048 is clamped to 2048 at capture.
- Distances are unsigned; comparisons are 18-bit unsigned with no saturation.

## Timing
- Reset values:
  - All outputs 0, except best_distance = 18'h3FFFF.
  - State is IDLE; idx = 0; watchdog = 0.
- Start-to-enable latency:
  - `start` accepted at edge t; `dcu_enable` is high in cycle t+1.
  - busy rises in cycle t+1 as well.
- Per-sample throughput:
  - Each sample takes 1 ISSUE cycle plus the DCU latency L, where `dcu_valid` arrives L cycles after the enable cycle.
  - The next `dcu_enable` comes 1 cycle after the `dcu_valid` cycle.
- `best_*` update on the same edge that samples `dcu_valid`. They are stable from `done` until the next accepted `start`.
- End of run: `done` is high in the cycle after the last `dcu_valid`; busy is low in that cycle.
- Reset mid-run: `rst` sampled high aborts everything at that edge; `dcu_enable` is low in the next cycle.
- Simultaneous `abort` and `dcu_valid` in WAIT: abort wins; no best update.

## Structure
- Package `dcu_sched_pkg` holds:
  - state enum;
  - HIST_BYTES and MAX_TRAIN defaults;
  - DIST_W=18, IDX_W=11, OFS_W=21;
  - DIST_MAX=18'h3FFFF.
- Sub-module `dcu_argmin`:
  - holds the best_distance/best_index registers and the strict-less compare;
  - inputs: clear, strobe, index, distance.
- The FSM, index counter and watchdog live in the top module.

## Test plan
- num_train=4, DCU model L=3 returning distances 500, 120, 120, 900 → four enables with offsets 0, 1024, 2048, 3072; best_index=1, best_distance=120; done one cycle after the 4th valid.
- num_train=0 → done in cycle t+1, no `dcu_enable`, best_valid=0, error=0.
- num_train=2, DCU never answers the second request → `done` and `error` fire WAIT_LIMIT cycles after the 2nd enable; best_valid=0.
- `abort` asserted in WAIT of sample 5 of 10 → IDLE next cycle, no `done`, no further enables; a new `start` then completes normally.
- `rst` pulsed during the sample 2 WAIT, plus a spurious `dcu_valid` while in IDLE → all outputs at reset values, best_distance=18'h3FFFF unchanged.
- num_train=2048 with distances equal to 262143−idx → last offset 21'h1FFC00, best_index=2047, best_distance=260096.
